dvs_fifo_bus_arbiter: RTL and testbench
=======================================

// Module: dvs_fifo_bus_arbiter
// PURPOSE
//  Round-robin arbiter for the shared event-FIFO write bus. It accepts fifo_req from NUM_REQ DVS AER-to-event
//  interfaces, returns one-hot single-cycle grants, and muxes the granted requester's registered write into
//  the FIFO write port. It holds off grants when FIFO free space cannot absorb in-flight writes.
//  Sits between the per-camera event interfaces and the event FIFO.
// PARAMETERS
//  NUM_REQ     4                    number of requesting event interfaces (>=1)
//  EVENT_BITS  pkg EVENT_BITS       width of one packed event
//  FREE_BITS   pkg FIFO_FREE_BITS   width of fifo_free (clog2(FIFO_DEPTH)+1)
// PORTS
//  clk          in   1                   single clock, rising edge
//  rst          in   1                   synchronous, active-high reset
//  enable       in   1                   1 = new grants allowed
//  req          in   NUM_REQ             per-requester fifo_req
//  grant        out  NUM_REQ             one-hot grant pulse (registered)
//  req_wr_en    in   NUM_REQ             per-requester fifo_wr_en (high 1 cycle after its grant)
//  req_event    in   NUM_REQ*EVENT_BITS  per-requester fifo_event, requester i at [i*EVENT_BITS +: EVENT_BITS]
//  fifo_free    in   FREE_BITS           free FIFO slots
//  fifo_wr_en   out  1                   FIFO write strobe (registered)
//  fifo_wdata   out  EVENT_BITS          FIFO write data (registered)
//  write_count  out  32                  total writes issued, saturating
//  proto_err    out  1                   sticky protocol-violation flag
// BEHAVIOUR
//  - Reset (rst=1 at edge): grant=0, fifo_wr_en=0, fifo_wdata=0, write_count=0, proto_err=0, rr pointer=NUM_REQ-1
//    (first grant goes to requester 0). In-flight writes are discarded. rst overrides all else.
//  - eligible = req & ~grant. A requester's req stays high during its grant cycle, so it is masked for that cycle.
//  - pending = (|grant) + (|req_wr_en) + fifo_wr_en (0..3). credit_ok = (fifo_free > pending).
//  - Each edge: if enable && |eligible && credit_ok, set grant to one-hot of the first eligible index searching
//    ptr+1, ptr+2, ... mod NUM_REQ, and set ptr to that index. Otherwise grant=0 and ptr holds.
//  - Grant is never high two consecutive cycles for the same requester. Different requesters may be granted
//    back-to-back: 1 grant/cycle for NUM_REQ>=2, 1 grant per 2 cycles for NUM_REQ=1.
//  - Timeline: grant[i] high in cycle t; req_wr_en[i] high in t+1; fifo_wr_en=1 and fifo_wdata=req_event[i]
//    in t+2. Latency from grant to FIFO write is 2 cycles.
//  - Write path: a 1-cycle-delayed copy of grant (grant_d) selects the data. fifo_wr_en <= |(req_wr_en & grant_d).
//    When fifo_wr_en<=0, fifo_wdata holds its previous value.
//  - write_count increments on every cycle in which fifo_wr_en=1, and saturates at 32'hFFFF_FFFF.
//  - proto_err is set on the next edge if either condition holds; it is cleared only by rst:
//    (a) req_wr_en has more than one bit set;
//    (b) req_wr_en[i]=1 with grant_d[i]=0. The offending write is dropped.
//  - enable=0 blocks new grants only. A grant already issued still completes its write.
//  - fifo_free=0 means no grants. fifo_free is treated as exact each cycle; no internal occupancy model.
// STRUCTURE
//  - Shared package dvs_ravens_pkg adds NUM_FIFO_REQ, FIFO_DEPTH and FIFO_FREE_BITS; EVENT_BITS is reused.
//  - One sub-module, dvs_rr_pick: combinational round-robin search (eligible, ptr -> onehot, idx, valid).
//    All state (grant, ptr, grant_d, write regs, counter, error) lives in the top module.
// TESTING
//  1. N=4, req[0] held until the edge after grant, req_event[0]=0x2A5, fifo_free=100
//     -> grant=0001 for 1 cycle; no regrant next cycle; fifo_wr_en=1 with fifo_wdata=0x2A5 two cycles after grant;
//     write_count=1.
//  2. All four req held high, fifo_free=100, each requester modelled like the event interface
//     -> grants 0001,0010,0100,1000,0001 on consecutive cycles; fifo_wr_en high every cycle once the pipe is full.
//  3. All req high, fifo_free held at 2
//     -> exactly 2 grants until pending drains, then none while pending>=2; fifo_wr_en count matches grant count.
//  4. req_wr_en=0100 with no prior grant[2]
//     -> proto_err=1 next cycle and stays 1; fifo_wr_en stays 0. Next, req_wr_en=0011 -> proto_err remains 1.
//  5. rst=1 in the cycle after grant[1]
//     -> grant, fifo_wr_en, write_count and proto_err are 0 at the next edge; the pending write never appears;
//     the first grant after release goes to requester 0.
//  6. enable=0 in the same cycle as grant[3]
//     -> that write still occurs 2 cycles later; no further grants while enable=0; round-robin resumes at
//     requester 0 when enable returns to 1.

Source files
------------

// File: rtl/dvs_ravens_pkg.sv
// Shared constants and helpers for the DVS event path: event width, FIFO geometry
// and the request-index width helper used by the FIFO write-bus arbiter.
package dvs_ravens_pkg;

  localparam int unsigned EVENT_BITS     = 24;
  localparam int unsigned NUM_FIFO_REQ   = 4;
  localparam int unsigned FIFO_DEPTH     = 128;
  localparam int unsigned FIFO_FREE_BITS = $clog2(FIFO_DEPTH) + 1;

  typedef logic [EVENT_BITS-1:0] event_t;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dvs_rr_pick.sv
// Combinational round-robin search: first eligible requester after ptr, wrapping,
// reported as one-hot, as an index, and with a valid flag.
module dvs_rr_pick #(
  parameter int unsigned NUM_REQ  = dvs_ravens_pkg::NUM_FIFO_REQ,
  parameter int unsigned IDX_BITS = dvs_ravens_pkg::idx_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  eligible,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  onehot,
  output logic [IDX_BITS-1:0] idx,
  output logic                valid
);

  import dvs_ravens_pkg::*;

  // Offsets 1..NUM_REQ visit ptr+1 first and ptr itself last.
  always_comb begin
    logic [IDX_BITS-1:0] cand;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_BITS'((32'(ptr) + k) % NUM_REQ);
      if (!valid && eligible[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dvs_fifo_bus_arbiter.sv
// Round-robin arbiter for the shared event-FIFO write bus: one-hot grant pulses,
// credit check against FIFO free space, registered write mux, counter and error flag.
module dvs_fifo_bus_arbiter #(
  parameter int unsigned NUM_REQ    = dvs_ravens_pkg::NUM_FIFO_REQ,
  parameter int unsigned EVENT_BITS = dvs_ravens_pkg::EVENT_BITS,
  parameter int unsigned FREE_BITS  = dvs_ravens_pkg::FIFO_FREE_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            grant,
  input  logic [NUM_REQ-1:0]            req_wr_en,
  input  logic [NUM_REQ*EVENT_BITS-1:0] req_event,
  input  logic [FREE_BITS-1:0]          fifo_free,
  output logic                          fifo_wr_en,
  output logic [EVENT_BITS-1:0]         fifo_wdata,
  output logic [31:0]                   write_count,
  output logic                          proto_err
);

  import dvs_ravens_pkg::*;

  localparam int unsigned IDX_BITS = idx_bits(NUM_REQ);

  logic [IDX_BITS-1:0]   ptr;
  logic [NUM_REQ-1:0]    grant_d;

  logic [NUM_REQ-1:0]    eligible_c;
  logic [NUM_REQ-1:0]    pick_onehot_c;
  logic [IDX_BITS-1:0]   pick_idx_c;
  logic                  pick_valid_c;
  logic [1:0]            pending_c;
  logic                  credit_ok_c;
  logic [NUM_REQ-1:0]    wr_hit_c;
  logic [EVENT_BITS-1:0] wr_data_c;
  logic                  multi_wr_c;
  logic                  stray_wr_c;
  logic                  grant_ok_c;

  // A requester keeps req high through its grant cycle, so mask it for that cycle.
  assign eligible_c = req & ~grant;

  // Writes already committed but not yet visible in fifo_free.
  assign pending_c   = 2'(|grant) + 2'(|req_wr_en) + 2'(fifo_wr_en);
  assign credit_ok_c = (fifo_free > FREE_BITS'(pending_c));
  assign grant_ok_c  = enable && pick_valid_c && credit_ok_c;

  dvs_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (IDX_BITS)
  ) u_pick (
    .eligible (eligible_c),
    .ptr      (ptr),
    .onehot   (pick_onehot_c),
    .idx      (pick_idx_c),
    .valid    (pick_valid_c)
  );

  // Only writes matching last cycle's grant are accepted; anything else is dropped.
  assign wr_hit_c   = req_wr_en & grant_d;
  assign multi_wr_c = ($countones(req_wr_en) > 1);
  assign stray_wr_c = |(req_wr_en & ~grant_d);

  always_comb begin
    wr_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (wr_hit_c[i]) begin
        wr_data_c = wr_data_c | req_event[i*EVENT_BITS +: EVENT_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      ptr         <= IDX_BITS'(NUM_REQ - 1);
      grant_d     <= '0;
      fifo_wr_en  <= 1'b0;
      fifo_wdata  <= '0;
      write_count <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (grant_ok_c) begin
        grant <= pick_onehot_c;
        ptr   <= pick_idx_c;
      end else begin
        grant <= '0;
      end

      grant_d    <= grant;
      fifo_wr_en <= |wr_hit_c;
      if (|wr_hit_c) begin
        fifo_wdata <= wr_data_c;
      end

      if (fifo_wr_en && (write_count != 32'hFFFF_FFFF)) begin
        write_count <= write_count + 32'd1;
      end

      if (multi_wr_c || stray_wr_c) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dvs_fifo_bus_arbiter.sv
// Directed, table-driven bench for the FIFO write-bus arbiter plus a short
// single-requester sequence exercising the one-grant-per-two-cycles limit.
module tb_dvs_fifo_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned EB = 24;
  localparam int unsigned FB = 8;

  typedef struct {
    logic          rst;
    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  wr;
    logic [FB-1:0] free;
    logic [N-1:0]  exp_grant;
    logic          exp_wr;
    logic [EB-1:0] exp_data;
    logic [31:0]   exp_cnt;
    logic          exp_err;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [N-1:0]    req_wr_en;
  logic [N*EB-1:0] req_event;
  logic [FB-1:0]   fifo_free;
  logic            fifo_wr_en;
  logic [EB-1:0]   fifo_wdata;
  logic [31:0]     write_count;
  logic            proto_err;

  logic            rst1;
  logic [0:0]      req1;
  logic [0:0]      grant1;
  logic [0:0]      wr1;
  logic [EB-1:0]   event1;
  logic            fifo_wr_en1;
  logic [EB-1:0]   fifo_wdata1;
  logic [31:0]     write_count1;
  logic            proto_err1;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dvs_fifo_bus_arbiter #(.NUM_REQ(N), .EVENT_BITS(EB), .FREE_BITS(FB)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .grant       (grant),
    .req_wr_en   (req_wr_en),
    .req_event   (req_event),
    .fifo_free   (fifo_free),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wdata  (fifo_wdata),
    .write_count (write_count),
    .proto_err   (proto_err)
  );

  dvs_fifo_bus_arbiter #(.NUM_REQ(1), .EVENT_BITS(EB), .FREE_BITS(FB)) dut1 (
    .clk         (clk),
    .rst         (rst1),
    .enable      (1'b1),
    .req         (req1),
    .grant       (grant1),
    .req_wr_en   (wr1),
    .req_event   (event1),
    .fifo_free   (8'd100),
    .fifo_wr_en  (fifo_wr_en1),
    .fifo_wdata  (fifo_wdata1),
    .write_count (write_count1),
    .proto_err   (proto_err1)
  );

  task automatic add(input logic r, input logic e, input logic [N-1:0] rq, input logic [N-1:0] w,
                     input logic [FB-1:0] f, input logic [N-1:0] g, input logic ew,
                     input logic [EB-1:0] d, input logic [31:0] c, input logic er);
    vec_t v;
    v.rst = r; v.en = e; v.req = rq; v.wr = w; v.free = f;
    v.exp_grant = g; v.exp_wr = ew; v.exp_data = d; v.exp_cnt = c; v.exp_err = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, got, exp);
    end
  endtask

  initial begin
    logic [0:0] exp_g1[5];
    logic       exp_w1[5];
    logic [0:0] rq1[5];
    logic [0:0] wv1[5];

    rst = 1'b1; enable = 1'b1; req = '0; req_wr_en = '0; fifo_free = 8'd100;
    req_event = {24'h000333, 24'h000222, 24'h000111, 24'h0002A5};
    rst1 = 1'b1; req1 = '0; wr1 = '0; event1 = 24'hABCDEF;

    //   rst en  req      wr       free    grant    wr  data       cnt  err
    // reset + single requester, write two cycles after grant
    add(1, 1, 4'b0000, 4'b0000, 100, 4'b0000, 0, 24'h000000, 0, 0);
    add(0, 1, 4'b0001, 4'b0000, 100, 4'b0001, 0, 24'h000000, 0, 0);
    add(0, 1, 4'b0001, 4'b0000, 100, 4'b0000, 0, 24'h000000, 0, 0);
    add(0, 1, 4'b0000, 4'b0001, 100, 4'b0000, 1, 24'h0002A5, 0, 0);
    add(0, 1, 4'b0000, 4'b0000, 100, 4'b0000, 0, 24'h0002A5, 1, 0);
    // all requesting: rotate 0,1,2,3,0 with writes streaming
    add(1, 1, 4'b0000, 4'b0000, 100, 4'b0000, 0, 24'h000000, 0, 0);
    add(0, 1, 4'b1111, 4'b0000, 100, 4'b0001, 0, 24'h000000, 0, 0);
    add(0, 1, 4'b1111, 4'b0000, 100, 4'b0010, 0, 24'h000000, 0, 0);
    add(0, 1, 4'b1111, 4'b0001, 100, 4'b0100, 1, 24'h0002A5, 0, 0);
    add(0, 1, 4'b1111, 4'b0010, 100, 4'b1000, 1, 24'h000111, 1, 0);
    add(0, 1, 4'b1111, 4'b0100, 100, 4'b0001, 1, 24'h000222, 2, 0);
    add(0, 1, 4'b0000, 4'b1000, 100, 4'b0000, 1, 24'h000333, 3, 0);
    add(0, 1, 4'b0000, 4'b0001, 100, 4'b0000, 1, 24'h0002A5, 4, 0);
    add(0, 1, 4'b0000, 4'b0000, 100, 4'b0000, 0, 24'h0002A5, 5, 0);
    // fifo_free=2: two grants, then stall until pending drops below 2
    add(0, 1, 4'b1111, 4'b0000,   2, 4'b0010, 0, 24'h0002A5, 5, 0);
    add(0, 1, 4'b1111, 4'b0000,   2, 4'b0100, 0, 24'h0002A5, 5, 0);
    add(0, 1, 4'b1111, 4'b0010,   2, 4'b0000, 1, 24'h000111, 5, 0);
    add(0, 1, 4'b1111, 4'b0100,   2, 4'b0000, 1, 24'h000222, 6, 0);
    add(0, 1, 4'b1111, 4'b0000,   2, 4'b1000, 0, 24'h000222, 7, 0);
    add(0, 1, 4'b0000, 4'b0000,   2, 4'b0000, 0, 24'h000222, 7, 0);
    add(0, 1, 4'b0000, 4'b1000,   2, 4'b0000, 1, 24'h000333, 7, 0);
    add(0, 1, 4'b0000, 4'b0000,   2, 4'b0000, 0, 24'h000333, 8, 0);
    // enable drops alongside grant[3]: write completes, no grants, resume at 0
    add(0, 1, 4'b1000, 4'b0000, 100, 4'b1000, 0, 24'h000333, 8, 0);
    add(0, 0, 4'b1111, 4'b0000, 100, 4'b0000, 0, 24'h000333, 8, 0);
    add(0, 0, 4'b1111, 4'b1000, 100, 4'b0000, 1, 24'h000333, 8, 0);
    add(0, 0, 4'b1111, 4'b0000, 100, 4'b0000, 0, 24'h000333, 9, 0);
    add(0, 1, 4'b1111, 4'b0000, 100, 4'b0001, 0, 24'h000333, 9, 0);
    add(0, 1, 4'b0000, 4'b0000, 100, 4'b0000, 0, 24'h000333, 9, 0);
    add(0, 1, 4'b0000, 4'b0001, 100, 4'b0000, 1, 24'h0002A5, 9, 0);
    add(0, 1, 4'b0000, 4'b0000, 100, 4'b0000, 0, 24'h0002A5, 10, 0);
    // stray write without grant sets sticky error; multi-bit write keeps it
    add(0, 1, 4'b0000, 4'b0100, 100, 4'b0000, 0, 24'h0002A5, 10, 1);
    add(0, 1, 4'b0000, 4'b0011, 100, 4'b0000, 0, 24'h0002A5, 10, 1);
    add(0, 1, 4'b0000, 4'b0000, 100, 4'b0000, 0, 24'h0002A5, 10, 1);
    // reset right after grant[1]: everything clears, next grant goes to 0
    add(0, 1, 4'b0010, 4'b0000, 100, 4'b0010, 0, 24'h0002A5, 10, 1);
    add(1, 1, 4'b0010, 4'b0000, 100, 4'b0000, 0, 24'h000000, 0, 0);
    add(0, 1, 4'b0011, 4'b0000, 100, 4'b0001, 0, 24'h000000, 0, 0);
    add(0, 1, 4'b0000, 4'b0000, 100, 4'b0000, 0, 24'h000000, 0, 0);
    // fifo_free boundaries: 0 blocks, 1 blocks while a write is pending
    add(0, 1, 4'b1111, 4'b0001,   0, 4'b0000, 1, 24'h0002A5, 0, 0);
    add(0, 1, 4'b1111, 4'b0000,   1, 4'b0000, 0, 24'h0002A5, 1, 0);
    add(0, 1, 4'b1111, 4'b0000,   1, 4'b0010, 0, 24'h0002A5, 1, 0);
    add(0, 1, 4'b0000, 4'b0000, 100, 4'b0000, 0, 24'h0002A5, 1, 0);
    add(0, 1, 4'b0000, 4'b0010, 100, 4'b0000, 1, 24'h000111, 1, 0);
    add(0, 1, 4'b0000, 4'b0000, 100, 4'b0000, 0, 24'h000111, 2, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; enable = vecs[i].en; req = vecs[i].req;
      req_wr_en = vecs[i].wr; fifo_free = vecs[i].free;
      @(posedge clk);
      #1;
      n_vec++;
      chk("grant",       i, 32'(grant),       32'(vecs[i].exp_grant));
      chk("fifo_wr_en",  i, 32'(fifo_wr_en),  32'(vecs[i].exp_wr));
      chk("fifo_wdata",  i, 32'(fifo_wdata),  32'(vecs[i].exp_data));
      chk("write_count", i, write_count,      vecs[i].exp_cnt);
      chk("proto_err",   i, 32'(proto_err),   32'(vecs[i].exp_err));
    end

    // Single requester: grant at most every other cycle, write lands two cycles later.
    rq1    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    wv1    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_g1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_w1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int s = 0; s < 5; s++) begin
      rst1 = (s == 0);
      req1 = rq1[s];
      wr1  = wv1[s];
      @(posedge clk);
      #1;
      n_vec++;
      chk("n1_grant",      100 + s, 32'(grant1),      32'(exp_g1[s]));
      chk("n1_fifo_wr_en", 100 + s, 32'(fifo_wr_en1), 32'(exp_w1[s]));
      chk("n1_proto_err",  100 + s, 32'(proto_err1),  32'd0);
    end
    chk("n1_fifo_wdata", 105, 32'(fifo_wdata1), 32'h00ABCDEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
